// File: rtl/mux_arb_pkg.sv
// Shared constants and state type for the 16-input round-robin mux arbiter.
package mux_arb_pkg;

  localparam int unsigned N_REQ       = 16;
  localparam int unsigned SEL_W       = 4;
  localparam int unsigned TIMEOUT_DEF = 15;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority encoder: first asserted request at or after ptr, wrapping.
module rr_priority_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  // Index arithmetic is SEL_W bits wide, so ptr + i wraps modulo 16 on its own.
  always_comb begin
    any = 1'b0;
    idx = ptr;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!any && req[ptr + SEL_W'(i)]) begin
        any = 1'b1;
        idx = ptr + SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter_16.sv
// Round-robin burst arbiter steering a 16:1, 16-bit mux onto a valid/ready output.
// Optional stall watchdog is compiled in with `define MUX_ARB_WATCHDOG_EN.
module mux_rr_arbiter_16
  import mux_arb_pkg::*;
#(
  parameter int unsigned N       = N_REQ,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic [N*DATA_W-1:0]   din,
  input  logic [N-1:0]          last,
  output logic [N-1:0]          gnt,
  output logic [SEL_W-1:0]      sel,
  output logic [DATA_W-1:0]     dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  timeout
);

  arb_state_e       state_q, state_d;
  logic [N-1:0]     gnt_d;
  logic [SEL_W-1:0] sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             timeout_d;
  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic             xfer;

`ifdef MUX_ARB_WATCHDOG_EN
  localparam int unsigned CNT_W = 4;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT;
`endif

  rr_priority_pick u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Data path is unregistered: live din/req steered by the registered select.
  assign dout_valid = (state_q == BUSY) && req[sel];
  assign dout       = dout_valid ? din[32'(sel) * DATA_W +: DATA_W] : '0;
  assign xfer       = dout_valid && dout_ready;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt;
    sel_d     = sel;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
`ifdef MUX_ARB_WATCHDOG_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = BUSY;
          sel_d   = pick_idx;
          gnt_d   = N'(1) << pick_idx;
`ifdef MUX_ARB_WATCHDOG_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        if (xfer && last[sel]) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = sel + SEL_W'(1);
        end
`ifdef MUX_ARB_WATCHDOG_EN
        else if (!xfer && (cnt_q == CNT_W'(TIMEOUT))) begin
          // Stalled too long: drop the burst and move priority past it.
          state_d   = IDLE;
          gnt_d     = '0;
          ptr_d     = sel + SEL_W'(1);
          timeout_d = 1'b1;
        end else begin
          cnt_d = xfer ? '0 : cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt     <= '0;
      sel     <= '0;
      ptr_q   <= '0;
      timeout <= 1'b0;
`ifdef MUX_ARB_WATCHDOG_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      sel     <= sel_d;
      ptr_q   <= ptr_d;
      timeout <= timeout_d;
`ifdef MUX_ARB_WATCHDOG_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter_16.sv
// Scoreboard bench for mux_rr_arbiter_16: per-requester burst queues plus a rotating-priority model.
module tb_mux_rr_arbiter_16;

  localparam int unsigned N   = 16;
  localparam int unsigned DW  = 16;
  localparam int unsigned TMO = 15;

  typedef struct packed {
    logic          lst;
    logic [DW-1:0] data;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] din = '0;
  logic [N-1:0]    last = '0;
  logic [N-1:0]    gnt;
  logic [3:0]      sel;
  logic [DW-1:0]   dout;
  logic            dout_valid;
  logic            dout_ready = 1'b1;
  logic            timeout;

  int checks = 0;
  int failures = 0;

  beat_t         drv_q[N][$];
  logic [DW-1:0] exp_q[N][$];
  logic [N-1:0]  drop = '0;
  int            ready_mode = 0;
  bit            gen_rand = 0;
  bit            drop_rand = 0;

  bit           m_busy = 0;
  bit           m_tmo = 0;
  int           m_sel = 0;
  int           m_ptr = 0;
  int           m_stall = 0;
  int           grants[$];
  int           xfer_cnt[N];
  int           tmo_cnt = 0;
  logic [N-1:0] prev_gnt = '0;

  mux_rr_arbiter_16 dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .din        (din),
    .last       (last),
    .gnt        (gnt),
    .sel        (sel),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .timeout    (timeout)
  );

  initial forever #5 clk = ~clk;

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: compare DUT against the model, then advance the model with the inputs of this cycle.
  always @(negedge clk) begin : monitor
    logic          exp_v;
    logic [DW-1:0] exp_d;
    logic          x;
    bit            found;
    exp_v = m_busy && req[m_sel];
    chk("gnt", longint'(gnt), m_busy ? (longint'(1) << m_sel) : 0);
    if (m_busy) chk("sel", longint'(sel), m_sel);
    chk("dout_valid", longint'(dout_valid), longint'(exp_v));
    exp_d = exp_v ? din[m_sel*DW +: DW] : '0;
    chk("dout", longint'(dout), longint'(exp_d));
    chk("timeout", longint'(timeout), longint'(m_tmo));
    if (timeout) tmo_cnt++;
    if (gnt != '0 && prev_gnt == '0) grants.push_back(int'(sel));
    prev_gnt = gnt;
    x = exp_v && dout_ready && !rst;
    if (x) begin
      xfer_cnt[m_sel]++;
      if (exp_q[m_sel].size() == 0) chk("sb_depth", exp_q[m_sel].size(), 1);
      else chk("sb_data", longint'(dout), longint'(exp_q[m_sel].pop_front()));
    end
    m_tmo = 0;
    if (rst) begin
      m_busy = 0; m_sel = 0; m_ptr = 0; m_stall = 0;
    end else if (m_busy) begin
      if (x) begin
        m_stall = 0;
        if (last[m_sel]) begin
          m_busy = 0;
          m_ptr  = (m_sel + 1) % N;
        end
      end
`ifdef MUX_ARB_WATCHDOG_EN
      else if (m_stall == TMO) begin
        m_busy = 0;
        m_ptr  = (m_sel + 1) % N;
        m_tmo  = 1;
      end
`endif
      else m_stall++;
    end else if (req != '0) begin
      found = 0;
      for (int i = 0; i < N; i++) begin
        if (!found && req[(m_ptr + i) % N]) begin
          found = 1;
          m_sel = (m_ptr + i) % N;
        end
      end
      m_busy  = 1;
      m_stall = 0;
    end
  end

  task automatic apply_inputs();
    for (int k = 0; k < N; k++) begin
      if (drv_q[k].size() > 0) begin
        req[k]          = !drop[k];
        din[k*DW +: DW] = drv_q[k][0].data;
        last[k]         = drv_q[k][0].lst;
      end else begin
        req[k]          = 1'b0;
        din[k*DW +: DW] = DW'($urandom);
        last[k]         = 1'($urandom);
      end
    end
  endtask

  task automatic push_burst(int k, int len);
    beat_t bt;
    for (int b = 0; b < len; b++) begin
      bt.data = DW'($urandom);
      bt.lst  = (b == len - 1);
      drv_q[k].push_back(bt);
      exp_q[k].push_back(bt.data);
    end
  endtask

  task automatic step();
    logic x;
    int   k;
    @(negedge clk);
    #1;
    x = dout_valid && dout_ready && !rst;
    k = int'(sel);
    @(posedge clk);
    #1;
    if (x && drv_q[k].size() > 0) drv_q[k].delete(0);
    if (gen_rand)
      for (int j = 0; j < N; j++)
        if (drv_q[j].size() == 0 && ($urandom % 6) == 0) push_burst(j, 1 + int'($urandom % 4));
    for (int j = 0; j < N; j++) drop[j] = drop_rand && (($urandom % 8) == 0);
    case (ready_mode)
      0:       dout_ready = 1'b1;
      1:       dout_ready = ($urandom % 4) != 0;
      default: dout_ready = 1'b0;
    endcase
    apply_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply_inputs();
    step();
    #1;
    chk("rst_gnt", longint'(gnt), 0);
    chk("rst_sel", longint'(sel), 0);
    chk("rst_valid", longint'(dout_valid), 0);
    rst  = 1'b0;
    drop = '0;
    for (int k = 0; k < N; k++) begin
      drv_q[k].delete();
      exp_q[k].delete();
    end
    apply_inputs();
  endtask

  task automatic chk_grant(string name, int pos, int exp);
    if (grants.size() <= pos) chk({name, "_missing"}, grants.size(), pos + 1);
    else chk(name, grants[pos], exp);
  endtask

  initial begin : stimulus
    int            g0;
    int            x5;
    bit            stalled;
    bit            found;
    logic [DW-1:0] held;
    int            p2[4];
    p2 = '{0, 3, 0, 3};
    for (int k = 0; k < N; k++) xfer_cnt[k] = 0;
    apply_inputs();
    do_reset();

    // Idle with no requests.
    repeat (10) begin
      step();
      #1;
      chk("idle_gnt", longint'(gnt), 0);
      chk("idle_valid", longint'(dout_valid), 0);
      chk("idle_dout", longint'(dout), 0);
    end

    // Requesters 0 and 3, single beats: alternate 0,3,0,3.
    g0 = grants.size();
    push_burst(0, 1); push_burst(0, 1);
    push_burst(3, 1); push_burst(3, 1);
    apply_inputs();
    repeat (12) step();
    for (int i = 0; i < 4; i++) chk_grant("p2_order", g0 + i, p2[i]);

    // Requester 5, 4 beats, ready low for 3 cycles on beat 2.
    x5 = xfer_cnt[5];
    push_burst(5, 4);
    apply_inputs();
    stalled = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (!stalled && drv_q[5].size() == 3) begin
        stalled    = 1;
        held       = drv_q[5][0].data;
        ready_mode = 2;
        dout_ready = 1'b0;
        #1;
        chk("p3_hold_gnt", longint'(gnt), 'h0020);
        chk("p3_hold_dout", longint'(dout), longint'(held));
        repeat (2) begin
          step();
          #1;
          chk("p3_hold_gnt", longint'(gnt), 'h0020);
          chk("p3_hold_dout", longint'(dout), longint'(held));
        end
        ready_mode = 0;
        dout_ready = 1'b1;
      end
    end
    chk("p3_stall_seen", stalled, 1);
    chk("p3_xfers", xfer_cnt[5] - x5, 4);
    // Pointer now 6: requester 7 beats requester 4.
    g0 = grants.size();
    push_burst(4, 1);
    push_burst(7, 1);
    apply_inputs();
    repeat (8) step();
    chk_grant("p3_ptr_first", g0, 7);
    chk_grant("p3_ptr_second", g0 + 1, 4);

    // All sixteen requesting: strict rotation.
    do_reset();
    g0 = grants.size();
    for (int k = 0; k < N; k++) begin
      push_burst(k, 1);
      push_burst(k, 1);
    end
    apply_inputs();
    repeat (70) step();
    for (int i = 0; i < 32; i++) chk_grant("p4_rotation", g0 + i, i % N);

    // Reset in the middle of a burst from requester 7.
    do_reset();
    ready_mode = 2;
    dout_ready = 1'b0;
    push_burst(7, 4);
    apply_inputs();
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      step();
      if (gnt == 16'h0080) found = 1;
    end
    chk("p5_grant7", found, 1);
    do_reset();
    ready_mode = 0;
    dout_ready = 1'b1;
    g0 = grants.size();
    push_burst(0, 1);
    push_burst(7, 1);
    apply_inputs();
    repeat (8) step();
    chk_grant("p5_after_rst_first", g0, 0);
    chk_grant("p5_after_rst_second", g0 + 1, 7);

    // Random traffic with drops and back-pressure, then drain.
    gen_rand   = 1;
    drop_rand  = 1;
    ready_mode = 1;
    repeat (1500) step();
    gen_rand   = 0;
    drop_rand  = 0;
    ready_mode = 0;
    repeat (150) step();
    for (int k = 0; k < N; k++) chk("p6_drained", exp_q[k].size(), 0);

    // Stalled burst on requester 2.
    do_reset();
    ready_mode = 2;
    dout_ready = 1'b0;
    g0 = grants.size();
`ifdef MUX_ARB_WATCHDOG_EN
    tmo_cnt = 0;
    push_burst(2, 2);
    push_burst(4, 1);
    apply_inputs();
    repeat (40) step();
    chk("p7_timeout_pulses", tmo_cnt, 2);
    chk_grant("p7_first", g0, 2);
    chk_grant("p7_after_timeout", g0 + 1, 4);
`else
    tmo_cnt = 0;
    push_burst(2, 2);
    apply_inputs();
    repeat (100) step();
    #1;
    chk("p7_held_gnt", longint'(gnt), 'h0004);
    chk("p7_no_timeout", tmo_cnt, 0);
`endif
    ready_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    failures++;
    $display("FAIL global_timeout: simulation exceeded time limit at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mux_rr_arbiter_16.md
# mux_rr_arbiter_16

Round-robin arbiter and sequencer for the 16-input, 16-bit multiplexer datapath. Sixteen requesters each present a 16-bit data word, a request and an end-of-burst flag. The block grants one requester at a time, holds the grant for a whole burst, and steers the 16:1 mux select. It delivers the chosen word to a single downstream consumer with a valid/ready handshake.

## Interface
Parameters:
- N, 16: number of requesters; fixed at 16 in this revision.
- DATA_W, 16: data word width.
- TIMEOUT, 15: stall-cycle limit; used only when the watchdog is compiled in (see Configuration).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  per-requester request, level-held.
- din  input  N*DATA_W  packed data; requester k occupies bits [k*DATA_W +: DATA_W].
- last  input  N  per-requester end-of-burst flag; qualified by a transfer.
- gnt  output  N  one-hot registered grant; all-zero when idle.
- sel  output  4  registered mux select; encoded index of gnt.
- dout  output  DATA_W  selected word; forced to 0 when dout_valid is low.
- dout_valid  output  1  equals req[sel] while BUSY; 0 otherwise.
- dout_ready  input  1  consumer accepts when high.
- timeout  output  1  one-cycle pulse when the watchdog forces a release.

## Operation
- States:
  - IDLE: gnt = 0.
  - BUSY: gnt is one-hot.
- Round-robin pointer ptr (4 bits). Requester ptr has the highest priority, then ptr+1, and so on, wrapping modulo 16.
- IDLE -> BUSY: when any req bit is high, pick the first asserted requester at or after ptr. Register gnt/sel with it.
- IDLE with req = 0: stay in IDLE; ptr is unchanged.
- BUSY:
  - dout = din slice of sel; dout_valid = req[sel].
  - A transfer is dout_valid && dout_ready.
- BUSY -> IDLE: on a transfer with last[sel] = 1. At the same edge, ptr <= sel+1 (wraps from 15 to 0).
- Granted requester drops req mid-burst: the grant is held and dout_valid is 0. No other requester is granted.
- Changes to non-granted req bits during BUSY are ignored.
- Simultaneous requests: resolved strictly by the rotating priority. There is no fixed bias.
- Reset, including mid-burst: the next state is IDLE, gnt = 0, sel = 0, ptr = 0, dout_valid = 0, dout = 0, timeout = 0. An in-flight burst is abandoned.

## Timing
- Grant latency: req seen in IDLE at edge t gives gnt/sel/dout_valid valid after edge t (from cycle t+1).
- Throughput: one word per cycle within a burst while dout_ready = 1.
- There is one mandatory IDLE bubble cycle between bursts. Re-arbitration happens in that cycle.
- dout and dout_valid are combinational from registered sel and the live req/din. There is no register stage on data.
- timeout is registered and high for exactly one cycle.

## Configuration
- Macro: MUX_ARB_WATCHDOG_EN.
- Defined:
  - A 4-bit stall counter counts consecutive BUSY cycles without a transfer. It clears on every transfer and on entry to BUSY.
  - When the counter reaches TIMEOUT, the next edge forces BUSY -> IDLE, sets ptr <= sel+1 and pulses timeout.
- Not defined: no counter is built, timeout is tied to 0, and a stalled burst holds the grant indefinitely.

## Structure
- Package mux_arb_pkg holds:
  - N_REQ = 16 and SEL_W = 4.
  - The state enum (IDLE, BUSY).
  - The default TIMEOUT constant.
- Sub-module rr_priority_pick: a combinational rotating-priority encoder.
  - Inputs: req[15:0] and ptr[3:0].
  - Outputs: any and idx[3:0].
  - It is instantiated once in the arbiter.
- The data steering is a plain 16:1 select on sel inside the top level.

## Test plan
- Reset, then req = 16'h0000 for 10 cycles -> gnt = 0, dout_valid = 0, dout = 0 throughout.
- req = 16'h0009 (requesters 0 and 3), 1-beat bursts with ready = 1 -> grants in the order 0, 3, 0, 3. Each grant is separated by one IDLE cycle.
- Requester 5 sends a 4-beat burst; ready is low on beat 2 for 3 cycles -> gnt stays 16'h0020 and dout holds beat 2. Exactly 4 transfers occur, then ptr = 6.
- All 16 requesters request continuously, single beats -> grant sequence 0..15 then back to 0; each requester is granted exactly once per 32 cycles.
- Reset asserted mid-burst while requester 7 is granted -> the next cycle shows gnt = 0 and sel = 0. With req = 16'h0081, re-arbitration grants requester 0 first.
- With MUX_ARB_WATCHDOG_EN and TIMEOUT = 15, requester 2 is granted and then ready is held at 0 -> a timeout pulse occurs 15 stall cycles after grant. The next grant goes to requester 3 or above. Without the macro, the grant is still held after 100 cycles.
